// File: rtl/audio_sram_ctrl.sv
// Record/playback controller for the single audio SRAM: mode FSM driven by key commands,
// plus a two-cycle write/read access sequencer shared by the ADC and DAC paths.
module audio_sram_ctrl #(
    parameter int unsigned       ADDR_W   = 18,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              bclk,
    input  logic              reset,
    input  logic              start_rec,
    input  logic              start_play,
    input  logic              pause,
    input  logic              stop,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              dac_req,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic [2:0]        mode,
    output logic [ADDR_W-1:0] rec_len,
    output logic              done
);

    localparam logic [2:0] M_IDLE       = 3'd0;
    localparam logic [2:0] M_REC        = 3'd1;
    localparam logic [2:0] M_PLAY       = 3'd2;
    localparam logic [2:0] M_REC_PAUSE  = 3'd3;
    localparam logic [2:0] M_PLAY_PAUSE = 3'd4;

    localparam logic [2:0] A_IDLE = 3'd0;
    localparam logic [2:0] A_W1   = 3'd1;
    localparam logic [2:0] A_W2   = 3'd2;
    localparam logic [2:0] A_R1   = 3'd3;
    localparam logic [2:0] A_R2   = 3'd4;

    logic [2:0]        mode_q, mode_d;
    logic [2:0]        acc_q, acc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] rec_len_q, rec_len_d;
    logic              rec_valid_q, rec_valid_d;
    logic              cap_pend_q, cap_pend_d;
    logic [DATA_W-1:0] dac_data_q, dac_data_d;
    logic              dac_valid_q, dac_valid_d;
    logic              done_q, done_d;

    logic rec_stop, cap_req, start_wr, start_rd, in_rec, in_play;

    assign in_rec   = (mode_q == M_REC) || (mode_q == M_REC_PAUSE);
    assign in_play  = (mode_q == M_PLAY) || (mode_q == M_PLAY_PAUSE);
    assign start_wr = (acc_q == A_IDLE) && adc_valid && (mode_q == M_REC);
    assign start_rd = (acc_q == A_IDLE) && dac_req && (mode_q == M_PLAY);
    assign rec_stop = in_rec && stop;
    assign cap_req  = rec_stop || cap_pend_q;

    always_comb begin
        mode_d      = mode_q;
        acc_d       = acc_q;
        addr_d      = addr_q;
        sram_addr_d = sram_addr_q;
        wdata_d     = wdata_q;
        rec_len_d   = rec_len_q;
        rec_valid_d = rec_valid_q;
        cap_pend_d  = cap_pend_q;
        dac_data_d  = dac_data_q;
        dac_valid_d = 1'b0;
        done_d      = 1'b0;

        case (mode_q)
            M_IDLE: begin
                if (!stop && !pause) begin
                    if (start_rec) begin
                        mode_d = M_REC;
                        addr_d = '0;
                    end else if (start_play && rec_valid_q) begin
                        mode_d = M_PLAY;
                        addr_d = '0;
                    end
                end
            end
            M_REC, M_REC_PAUSE: begin
                if (stop) begin
                    mode_d = M_IDLE;
                    done_d = 1'b1;
                end else if (pause) begin
                    mode_d = (mode_q == M_REC) ? M_REC_PAUSE : M_REC;
                end
            end
            M_PLAY, M_PLAY_PAUSE: begin
                if (stop) begin
                    mode_d = M_IDLE;
                    done_d = 1'b1;
                end else if (pause) begin
                    mode_d = (mode_q == M_PLAY) ? M_PLAY_PAUSE : M_PLAY;
                end
            end
            default: mode_d = M_IDLE;
        endcase

        // rec_len must count a write still in flight, so capture waits for it to finish
        if (cap_req && acc_q != A_W2) begin
            if (acc_q == A_W1 || start_wr) begin
                cap_pend_d = 1'b1;
            end else begin
                rec_len_d   = (addr_q == '0) ? '0 : addr_q - 1'b1;
                rec_valid_d = (addr_q != '0);
                cap_pend_d  = 1'b0;
            end
        end

        case (acc_q)
            A_IDLE: begin
                if (start_wr) begin
                    acc_d       = A_W1;
                    wdata_d     = adc_data;
                    sram_addr_d = addr_q;
                end else if (start_rd) begin
                    acc_d       = A_R1;
                    sram_addr_d = addr_q;
                end
            end
            A_W1: acc_d = A_W2;
            A_W2: begin
                acc_d = A_IDLE;
                if (sram_addr_q != MAX_ADDR) begin
                    addr_d = addr_q + 1'b1;
                end
                if (cap_req || sram_addr_q == MAX_ADDR) begin
                    rec_len_d   = sram_addr_q;
                    rec_valid_d = 1'b1;
                    cap_pend_d  = 1'b0;
                end
                if (sram_addr_q == MAX_ADDR && in_rec && !stop) begin
                    mode_d = M_IDLE;
                    done_d = 1'b1;
                end
            end
            A_R1: acc_d = A_R2;
            A_R2: begin
                acc_d       = A_IDLE;
                dac_data_d  = sram_dq_i;
                dac_valid_d = 1'b1;
                addr_d      = addr_q + 1'b1;
                if (sram_addr_q == rec_len_q && in_play && !stop) begin
                    mode_d = M_IDLE;
                    done_d = 1'b1;
                end
            end
            default: acc_d = A_IDLE;
        endcase
    end

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            mode_q      <= M_IDLE;
            acc_q       <= A_IDLE;
            addr_q      <= '0;
            sram_addr_q <= '0;
            wdata_q     <= '0;
            rec_len_q   <= '0;
            rec_valid_q <= 1'b0;
            cap_pend_q  <= 1'b0;
            dac_data_q  <= '0;
            dac_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            addr_q      <= addr_d;
            sram_addr_q <= sram_addr_d;
            wdata_q     <= wdata_d;
            rec_len_q   <= rec_len_d;
            rec_valid_q <= rec_valid_d;
            cap_pend_q  <= cap_pend_d;
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
            done_q      <= done_d;
        end
    end

    // Strobes decode straight from the access state so reset deasserts them at once
    assign sram_we_n  = (acc_q != A_W1);
    assign sram_dq_oe = (acc_q == A_W1) || (acc_q == A_W2);
    assign sram_oe_n  = !((acc_q == A_R1) || (acc_q == A_R2));
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = wdata_q;
    assign dac_data   = dac_data_q;
    assign dac_valid  = dac_valid_q;
    assign mode       = mode_q;
    assign rec_len    = rec_len_q;
    assign done       = done_q;

endmodule

// File: tb/tb_audio_sram_ctrl.sv
// Bench for audio_sram_ctrl: directed scenarios plus random command/sample traffic,
// checked against a behavioural record/playback model.
module tb_audio_sram_ctrl;

    localparam int AW   = 5;
    localparam int DW   = 16;
    localparam int MAXA = (1 << AW) - 1;

    localparam int OpRec   = 0;
    localparam int OpPlay  = 1;
    localparam int OpPause = 2;
    localparam int OpStop  = 3;
    localparam int OpAdc   = 4;
    localparam int OpDac   = 5;

    logic          bclk, reset;
    logic          start_rec, start_play, pause, stop;
    logic [DW-1:0] adc_data;
    logic          adc_valid, dac_req;
    logic [DW-1:0] dac_data;
    logic          dac_valid;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_o, sram_dq_i;
    logic          sram_dq_oe, sram_we_n, sram_oe_n;
    logic [2:0]    mode;
    logic [AW-1:0] rec_len;
    logic          done;

    audio_sram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .bclk       (bclk),
        .reset      (reset),
        .start_rec  (start_rec),
        .start_play (start_play),
        .pause      (pause),
        .stop       (stop),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .dac_req    (dac_req),
        .dac_data   (dac_data),
        .dac_valid  (dac_valid),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .mode       (mode),
        .rec_len    (rec_len),
        .done       (done)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    // SRAM device model
    logic [DW-1:0] sram_mem [0:MAXA];
    always @(negedge bclk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_o;
    end
    assign sram_dq_i = sram_oe_n ? 16'hDEAD : sram_mem[sram_addr];

    // Reference model state
    int            ref_mode, ref_addr, ref_len;
    bit            ref_valid;
    logic [DW-1:0] ref_mem [0:MAXA];

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] last_rdata;
    logic [DW-1:0] first_word;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic string op_name(input int op);
        case (op)
            OpRec:   return "rec";
            OpPlay:  return "play";
            OpPause: return "pause";
            OpStop:  return "stop";
            OpAdc:   return "adc";
            default: return "dac";
        endcase
    endfunction

    task automatic model_reset();
        ref_mode  = 0;
        ref_addr  = 0;
        ref_len   = 0;
        ref_valid = 1'b0;
    endtask

    task automatic run_op(input int op, input logic [DW-1:0] d);
        bit            e_done, e_wr, e_rd;
        logic [DW-1:0] e_rdata;
        int            wa;
        int            n_done, n_we, n_dqoe, n_oe, n_valid, valid_at;
        logic [DW-1:0] vdata;
        string         nm;
        e_done = 0; e_wr = 0; e_rd = 0; e_rdata = '0; wa = 0;
        n_done = 0; n_we = 0; n_dqoe = 0; n_oe = 0; n_valid = 0; valid_at = -1; vdata = '0;
        nm = op_name(op);

        case (op)
            OpRec: if (ref_mode == 0) begin ref_mode = 1; ref_addr = 0; end
            OpPlay: if (ref_mode == 0 && ref_valid) begin ref_mode = 2; ref_addr = 0; end
            OpPause: begin
                if (ref_mode == 1) ref_mode = 3;
                else if (ref_mode == 3) ref_mode = 1;
                else if (ref_mode == 2) ref_mode = 4;
                else if (ref_mode == 4) ref_mode = 2;
            end
            OpStop: begin
                if (ref_mode == 1 || ref_mode == 3) begin
                    e_done    = 1;
                    ref_valid = (ref_addr > 0);
                    ref_len   = (ref_addr > 0) ? ref_addr - 1 : 0;
                    ref_mode  = 0;
                end else if (ref_mode == 2 || ref_mode == 4) begin
                    e_done   = 1;
                    ref_mode = 0;
                end
            end
            OpAdc: if (ref_mode == 1) begin
                e_wr = 1;
                wa   = ref_addr;
                ref_mem[wa] = d;
                ref_addr++;
                if (ref_addr == MAXA + 1) begin
                    ref_mode = 0; ref_len = MAXA; ref_valid = 1'b1; e_done = 1;
                end
            end
            default: if (ref_mode == 2) begin
                e_rd    = 1;
                e_rdata = ref_mem[ref_addr];
                if (ref_addr == ref_len) begin ref_mode = 0; e_done = 1; end
                ref_addr++;
            end
        endcase

        @(negedge bclk);
        case (op)
            OpRec:   start_rec  = 1'b1;
            OpPlay:  start_play = 1'b1;
            OpPause: pause      = 1'b1;
            OpStop:  stop       = 1'b1;
            OpAdc:   begin adc_valid = 1'b1; adc_data = d; end
            default: dac_req    = 1'b1;
        endcase
        for (int i = 1; i <= 8; i++) begin
            @(negedge bclk);
            if (i == 1) begin
                start_rec = 0; start_play = 0; pause = 0; stop = 0; adc_valid = 0; dac_req = 0;
            end
            if (done)       n_done++;
            if (!sram_we_n) n_we++;
            if (sram_dq_oe) n_dqoe++;
            if (!sram_oe_n) n_oe++;
            if (dac_valid) begin n_valid++; valid_at = i; vdata = dac_data; end
        end
        last_rdata = vdata;

        check_eq({nm, "_done"}, 32'(n_done), 32'(e_done));
        check_eq({nm, "_we_cycles"}, 32'(n_we), e_wr ? 32'd1 : 32'd0);
        check_eq({nm, "_dqoe_cycles"}, 32'(n_dqoe), e_wr ? 32'd2 : 32'd0);
        check_eq({nm, "_oe_cycles"}, 32'(n_oe), e_rd ? 32'd2 : 32'd0);
        check_eq({nm, "_valid_cnt"}, 32'(n_valid), 32'(e_rd));
        if (e_rd) begin
            check_eq({nm, "_latency"}, 32'(valid_at), 32'd3);
            check_eq({nm, "_rdata"}, 32'(vdata), 32'(e_rdata));
        end
        if (e_wr) check_eq({nm, "_wr_mem"}, 32'(sram_mem[wa]), 32'(d));
        check_eq({nm, "_mode"}, 32'(mode), 32'(ref_mode));
        check_eq({nm, "_rec_len"}, 32'(rec_len), 32'(ref_len));
    endtask

    initial begin
        logic [DW-1:0] c;
        int            n_done;
        start_rec = 0; start_play = 0; pause = 0; stop = 0;
        adc_valid = 0; adc_data = '0; dac_req = 0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge bclk);
        reset = 1'b0;
        @(negedge bclk);
        check_eq("rst_mode", 32'(mode), 32'd0);
        check_eq("rst_rec_len", 32'(rec_len), 32'd0);
        check_eq("rst_we_n", 32'(sram_we_n), 32'd1);
        check_eq("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check_eq("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check_eq("rst_dac_data", 32'(dac_data), 32'd0);
        check_eq("rst_dac_valid", 32'(dac_valid), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);

        // Play with no recording is ignored
        run_op(OpPlay, '0);

        // Basic record of four words
        run_op(OpRec, '0);
        run_op(OpAdc, 16'h1111);
        run_op(OpAdc, 16'h2222);
        run_op(OpAdc, 16'h3333);
        run_op(OpAdc, 16'h4444);
        run_op(OpStop, '0);
        check_eq("rec4_len", 32'(rec_len), 32'd3);
        check_eq("rec4_mem0", 32'(sram_mem[0]), 32'h1111);
        check_eq("rec4_mem3", 32'(sram_mem[3]), 32'h4444);

        // Playback with one extra request after the auto-stop
        run_op(OpPlay, '0);
        run_op(OpDac, '0); check_eq("play_d0", 32'(last_rdata), 32'h1111);
        run_op(OpDac, '0); check_eq("play_d1", 32'(last_rdata), 32'h2222);
        run_op(OpDac, '0); check_eq("play_d2", 32'(last_rdata), 32'h3333);
        run_op(OpDac, '0); check_eq("play_d3", 32'(last_rdata), 32'h4444);
        check_eq("play_end_mode", 32'(mode), 32'd0);
        run_op(OpDac, '0);

        // Paused samples are dropped
        run_op(OpRec, '0);
        run_op(OpAdc, 16'hA001);
        run_op(OpAdc, 16'hA002);
        run_op(OpPause, '0);
        check_eq("rp_mode", 32'(mode), 32'd3);
        for (int i = 0; i < 3; i++) run_op(OpAdc, 16'hB000 + 16'(i));
        run_op(OpPause, '0);
        run_op(OpAdc, 16'hA003);
        run_op(OpStop, '0);
        check_eq("pause_mem0", 32'(sram_mem[0]), 32'hA001);
        check_eq("pause_mem1", 32'(sram_mem[1]), 32'hA002);
        check_eq("pause_mem2", 32'(sram_mem[2]), 32'hA003);
        check_eq("pause_len", 32'(rec_len), 32'd2);

        // Fill to the last address: auto-stop, no wrap
        run_op(OpRec, '0);
        for (int i = 0; i < MAXA + 2; i++) run_op(OpAdc, 16'hC000 + 16'(i));
        check_eq("full_len", 32'(rec_len), 32'(MAXA));
        check_eq("full_mode", 32'(mode), 32'd0);
        check_eq("full_addr", 32'(sram_addr), 32'(MAXA));
        check_eq("full_mem0", 32'(sram_mem[0]), 32'hC000);
        check_eq("full_memmax", 32'(sram_mem[MAXA]), 32'hC000 + 32'(MAXA));

        // stop+pause together while a write sits in W1
        run_op(OpRec, '0);
        run_op(OpAdc, 16'hD001);
        run_op(OpAdc, 16'hD002);
        c = 16'hD003;
        @(negedge bclk); adc_valid = 1'b1; adc_data = c;
        @(negedge bclk); adc_valid = 1'b0;
        check_eq("sp_w1_we_n", 32'(sram_we_n), 32'd0);
        stop = 1'b1; pause = 1'b1;
        n_done = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge bclk);
            if (i == 1) begin stop = 1'b0; pause = 1'b0; end
            if (done) n_done++;
        end
        check_eq("sp_done", 32'(n_done), 32'd1);
        check_eq("sp_mode", 32'(mode), 32'd0);
        check_eq("sp_len", 32'(rec_len), 32'd2);
        check_eq("sp_mem2", 32'(sram_mem[2]), 32'(c));
        ref_mem[2] = c; ref_mode = 0; ref_len = 2; ref_valid = 1'b1; ref_addr = 3;
        run_op(OpPlay, '0);
        for (int i = 0; i < 3; i++) run_op(OpDac, '0);

        // Asynchronous reset during W1
        run_op(OpRec, '0);
        @(negedge bclk); adc_valid = 1'b1; adc_data = 16'hEEEE;
        @(negedge bclk); adc_valid = 1'b0;
        check_eq("ar_w1_we_n", 32'(sram_we_n), 32'd0);
        check_eq("ar_w1_dq_oe", 32'(sram_dq_oe), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("ar_we_n", 32'(sram_we_n), 32'd1);
        check_eq("ar_dq_oe", 32'(sram_dq_oe), 32'd0);
        check_eq("ar_mode", 32'(mode), 32'd0);
        @(negedge bclk);
        reset = 1'b0;
        model_reset();
        run_op(OpPlay, '0);

        // Random command and sample traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 6)       run_op(OpRec, '0);
            else if (r < 14) run_op(OpPlay, '0);
            else if (r < 20) run_op(OpPause, '0);
            else if (r < 25) run_op(OpStop, '0);
            else if (r < 65) run_op(OpAdc, 16'($urandom));
            else             run_op(OpDac, '0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/audio_sram_ctrl.md
Name: audio_sram_ctrl

Overview:
- Record/playback controller that owns the single 256K x 16 audio SRAM.
- Takes debounced key commands and sequences REC/PLAY/PAUSE modes.
- Owns the address counters and the recorded length.
- Sequences SRAM write cycles for ADC samples and read cycles for DAC samples, so only one requester ever drives the SRAM. Sits between the ADC capture path, the DAC playback path and the SRAM pins.

Parameters:
ADDR_W, 18, SRAM address width
DATA_W, 16, sample/SRAM data width
MAX_ADDR, 2**ADDR_W-1, last usable SRAM word

Ports:
bclk  in  1  codec bit clock, all logic on rising edge
reset  in  1  asynchronous active-high reset
start_rec  in  1  one-cycle command pulse
start_play  in  1  one-cycle command pulse
pause  in  1  one-cycle command pulse (toggles pause)
stop  in  1  one-cycle command pulse
adc_data  in  DATA_W  captured sample, stable while adc_valid high
adc_valid  in  1  one-cycle pulse, new ADC sample ready
dac_req  in  1  one-cycle pulse, DAC needs next sample
dac_data  out  DATA_W  sample read from SRAM
dac_valid  out  1  one-cycle pulse, dac_data updated
sram_addr  out  ADDR_W  SRAM address
sram_dq_o  out  DATA_W  write data
sram_dq_i  in  DATA_W  read data
sram_dq_oe  out  1  1 = drive sram_dq_o onto the bus
sram_we_n  out  1  active-low write strobe
sram_oe_n  out  1  active-low output enable
mode  out  3  0 IDLE, 1 REC, 2 PLAY, 3 REC_PAUSE, 4 PLAY_PAUSE
rec_len  out  ADDR_W  words recorded minus 1 (last valid address)
done  out  1  one-cycle pulse when REC or PLAY ends

Behaviour:
- Reset (async) values:
  - mode IDLE; addr counter 0; rec_len 0.
  - sram_we_n=1, sram_oe_n=1, sram_dq_oe=0.
  - dac_data 0; dac_valid 0; done 0; access FSM A_IDLE.
- Mode FSM, commands evaluated on the cycle they arrive.
  - Priority when several commands arrive together: stop > pause > start_rec > start_play.
  - IDLE: start_rec -> REC, addr=0. start_play -> PLAY, addr=0, only if a recording exists (rec_valid flag set), otherwise ignored.
  - REC: pause -> REC_PAUSE. stop -> IDLE, rec_len=addr-1 (0 if no word written), rec_valid=1 if at least one word written, done=1. start_* ignored.
  - PLAY: pause -> PLAY_PAUSE. stop -> IDLE, done=1. start_* ignored.
  - REC_PAUSE / PLAY_PAUSE: pause -> back to REC / PLAY with addr kept. stop behaves as in REC / PLAY. start_* ignored.
- Access FSM:
  - Write (A_IDLE -> W1 -> W2 -> A_IDLE): on adc_valid in REC, latch adc_data and addr.
    - W1: sram_dq_oe=1, sram_we_n=0.
    - W2: sram_we_n=1, sram_dq_oe still 1 (hold).
    - Then addr += 1.
  - Read (A_IDLE -> R1 -> R2 -> A_IDLE): on dac_req in PLAY.
    - R1: sram_oe_n=0.
    - R2: sram_oe_n still 0; sram_dq_i captured into dac_data at the end of R2.
    - dac_valid pulses the following cycle; addr += 1.
  - Latency: dac_req to dac_valid is 3 cycles.
  - adc_valid is ignored outside REC; dac_req is ignored outside PLAY, including during pause.
  - A request arriving while the access FSM is busy is dropped. It cannot occur at codec rates.
- Access/mode interaction:
  - A mode change never aborts an in-flight access; the access completes first.
  - The stop/pause that caused the change is applied immediately to mode; it is not deferred.
  - rec_len is captured on stop only after any write in flight has incremented addr.
- Boundaries:
  - REC: the write to MAX_ADDR completes, then automatic stop: mode IDLE, rec_len=MAX_ADDR, done=1. No address wrap.
  - PLAY: the read of address rec_len completes, then automatic stop with done=1.
  - A new start_rec overwrites from 0. rec_len/rec_valid keep their old values until that recording stops.
  - Reset mid-access forces the strobes inactive immediately (async) and clears rec_valid.
- When idle, sram_addr holds the last used address; strobes stay inactive.

Test Plan:
- Reset, start_rec, 4 adc_valid pulses with data 0x1111..0x4444 spaced 20 cycles, stop -> SRAM model holds 0x1111..0x4444 at 0..3; each write shows we_n low for exactly 1 cycle with dq_oe high for 2; rec_len=3; done pulses once.
- Then start_play, 5 dac_req pulses -> dac_data 0x1111, 0x2222, 0x3333, 0x4444 each 3 cycles after its req; mode returns to IDLE with done after the 4th read; 5th req is ignored (no dac_valid).
- REC, 2 writes, pause, 3 adc_valid, pause, 1 write, stop -> SRAM addresses 0..2 hold only the non-paused samples; rec_len=2.
- Force the addr counter to MAX_ADDR-1 in REC, 3 adc_valid -> writes at MAX_ADDR-1 and MAX_ADDR, auto-stop, rec_len=MAX_ADDR; the 3rd sample is not written and addr does not wrap to 0.
- stop and pause in the same cycle during REC, with a write in W1 -> write completes, mode IDLE, rec_len includes that word. start_play from IDLE straight after reset is ignored.
- Assert reset during W1 -> we_n=1, dq_oe=0 in the same cycle without waiting for a clock edge; mode IDLE; a following start_play is ignored.
